// File: rtl/lsu_data_mem.sv
// lsu_data_mem: big-endian LSU data memory with sized, misaligned and byte-reversed loads/stores.
// Vectors are [31:0] here, so byte 0 of a word (most significant) sits in [31:24].
module lsu_data_mem #(
   parameter int RS_ID_WIDTH  = 7,
   parameter int MEMORY_DEPTH = 32768
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   input_valid,
   output logic                   input_ready,
   input  logic [RS_ID_WIDTH-1:0] rs_id_in,
   input  logic [4:0]             result_reg_addr_in,
   input  logic [31:0]            mem_address,
   input  logic                   is_write,
   input  logic [1:0]             access_size,
   input  logic                   sign_extend,
   input  logic                   byte_reverse,
   input  logic [31:0]            mem_write_data,
   output logic                   output_valid,
   input  logic                   output_ready,
   output logic [RS_ID_WIDTH-1:0] rs_id_out,
   output logic [4:0]             result_reg_addr_out,
   output logic [31:0]            mem_read_data
);
   localparam int AW = $clog2(MEMORY_DEPTH);
   typedef enum logic [1:0] {IDLE, SECOND, RESP} state_t;
   state_t state_q, state_d;
   logic [31:0] mem [MEMORY_DEPTH];
   logic [31:0] rdata_q, w0_q, wlo_q, data_q, dl, whi, wlo, wd, lw0, lw1, gh, g, r, res;
   logic [3:0] ml, mhi, mlo, mlo_q, wm;
   logic [AW-1:0] idx, idx_q, addr;
   logic [RS_ID_WIDTH-1:0] rs_q, rs_out_q;
   logic [4:0] rd_q, rd_out_q, sh_q;
   logic [4:0] sh;
   logic [2:0] nb;
   logic [1:0] off, off_q, sz_q;
   logic wr_q, sx_q, rev_q, split, split_q, acc, we, ov_q, unused_addr;

   function automatic logic [2:0] nbytes(input logic [1:0] sz);
      return sz == 2'd0 ? 3'd1 : sz == 2'd1 ? 3'd2 : 3'd4;
   endfunction

   function automatic logic [31:0] brev(input logic [31:0] d, input logic [1:0] sz);
      return sz == 2'd0 ? d : sz == 2'd1 ? {d[31:16], d[7:0], d[15:8]} : {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   assign unused_addr = ^(mem_address >> (AW + 2));
   assign idx   = mem_address[AW+1:2];
   assign off   = mem_address[1:0];
   assign sh    = {off, 3'b0};
   assign nb    = nbytes(access_size);
   assign split = {1'b0, off} + nb > 3'd4;
   assign input_ready = !rst && state_q == IDLE && (!ov_q || output_ready);
   assign acc   = input_valid && input_ready;

   // Store data is left-aligned, then spread over the two words the access may touch.
   assign dl  = (byte_reverse ? brev(mem_write_data, access_size) : mem_write_data) << {3'd4 - nb, 3'b0};
   assign whi = dl >> sh;
   assign wlo = dl << (6'd32 - {1'b0, sh});
   assign ml  = access_size == 2'd0 ? 4'b1000 : access_size == 2'd1 ? 4'b1100 : 4'b1111;
   assign mhi = ml >> off;
   assign mlo = ml << (3'd4 - {1'b0, off});

   assign addr = state_q == SECOND ? idx_q + AW'(1) : idx;
   assign wd   = state_q == SECOND ? wlo_q : whi;
   assign wm   = state_q == SECOND ? mlo_q : mhi;
   assign we   = !rst && ((acc && is_write) || (state_q == SECOND && wr_q));

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) if (we && wm[b]) mem[addr][8*b +: 8] <= wd[8*b +: 8];
      rdata_q <= mem[addr];
   end

   assign sh_q = {off_q, 3'b0};
   assign lw0  = split_q ? w0_q : rdata_q;
   assign lw1  = split_q ? rdata_q : '0;
   assign gh   = (lw0 << sh_q) | (lw1 >> (6'd32 - {1'b0, sh_q}));
   assign g    = gh >> {3'd4 - nbytes(sz_q), 3'b0};
   assign r    = rev_q ? brev(g, sz_q) : g;
   assign res  = (sx_q && sz_q == 2'd0) ? {{24{r[7]}}, r[7:0]} :
                 (sx_q && sz_q == 2'd1) ? {{16{r[15]}}, r[15:0]} : r;

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && acc) state_d = split ? SECOND : is_write ? IDLE : RESP;
      else if (state_q == SECOND) state_d = wr_q ? IDLE : RESP;
      else if (state_q == RESP) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (acc) begin
         idx_q   <= idx;
         off_q   <= off;
         sz_q    <= access_size;
         wr_q    <= is_write;
         sx_q    <= sign_extend;
         rev_q   <= byte_reverse;
         split_q <= split;
         wlo_q   <= wlo;
         mlo_q   <= mlo;
         rs_q    <= rs_id_in;
         rd_q    <= result_reg_addr_in;
      end
      if (state_q == SECOND) w0_q <= rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ov_q     <= 1'b0;
         rs_out_q <= '0;
         rd_out_q <= '0;
         data_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == RESP) begin
            ov_q     <= 1'b1;
            rs_out_q <= rs_q;
            rd_out_q <= rd_q;
            data_q   <= res;
         end else if (ov_q && output_ready) ov_q <= 1'b0;
      end
   end

   assign output_valid        = ov_q;
   assign rs_id_out           = rs_out_q;
   assign result_reg_addr_out = rd_out_q;
   assign mem_read_data       = data_q;
endmodule

// File: tb/tb_lsu_data_mem.sv
// tb_lsu_data_mem: directed and random requests checked every cycle against a
// byte-array memory model with cycle-exact result timing and ready expectations.
module tb_lsu_data_mem;
   localparam int RW = 7;
   localparam int D  = 256;
   localparam int NB = D * 4;

   logic clk = 0, rst = 1;
   logic input_valid = 0, input_ready, is_write = 0, sign_extend = 0, byte_reverse = 0;
   logic [RW-1:0] rs_id_in = 0, rs_id_out;
   logic [4:0] result_reg_addr_in = 0, result_reg_addr_out;
   logic [31:0] mem_address = 0, mem_write_data = 0, mem_read_data;
   logic [1:0] access_size = 0;
   logic output_valid, output_ready = 1;

   always #5 clk = ~clk;

   lsu_data_mem #(.RS_ID_WIDTH(RW), .MEMORY_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .input_valid(input_valid), .input_ready(input_ready),
      .rs_id_in(rs_id_in), .result_reg_addr_in(result_reg_addr_in), .mem_address(mem_address),
      .is_write(is_write), .access_size(access_size), .sign_extend(sign_extend),
      .byte_reverse(byte_reverse), .mem_write_data(mem_write_data), .output_valid(output_valid),
      .output_ready(output_ready), .rs_id_out(rs_id_out), .result_reg_addr_out(result_reg_addr_out),
      .mem_read_data(mem_read_data)
   );

   typedef struct {int due; logic [RW-1:0] rs; logic [4:0] rd; logic [31:0] d;} exp_t;
   exp_t q[$];
   int acc_cyc[$];
   int n_cmp = 0, n_bad = 0, cyc = 0, next_free = 0, pend_n = 0, or_mode = 1;
   int pend_a [4];
   logic [7:0] pend_v [4];
   logic [7:0] bm [NB];
   logic rst_prev = 0;
   logic [31:0] last_d;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
   endfunction

   function automatic logic [31:0] mload(input logic [31:0] a, input logic [1:0] sz, input logic sx, input logic rv);
      int n, base;
      logic [7:0] b [4];
      logic [31:0] v;
      n = nbytes(sz);
      base = int'(a & (NB - 1));
      v = 0;
      for (int i = 0; i < n; i++) b[i] = bm[(base + i) % NB];
      for (int i = 0; i < n; i++) v = (v << 8) | 32'(rv ? b[n - 1 - i] : b[i]);
      if (sx && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 1);
      return v;
   endfunction

   task automatic accept();
      int n, base, off;
      logic [7:0] v;
      bit sp;
      exp_t e;
      n = nbytes(access_size);
      base = int'(mem_address & (NB - 1));
      off = base % 4;
      sp = off + n > 4;
      if (is_write) begin
         for (int i = 0; i < n; i++) begin
            v = 8'(mem_write_data >> (8 * (byte_reverse ? i : n - 1 - i)));
            if (off + i < 4) bm[(base + i) % NB] = v;
            else begin
               pend_a[pend_n] = (base + i) % NB;
               pend_v[pend_n] = v;
               pend_n++;
            end
         end
         next_free = cyc + (sp ? 2 : 1);
      end else begin
         e.due = cyc + (sp ? 3 : 2);
         e.rs = rs_id_in;
         e.rd = result_reg_addr_in;
         e.d = mload(mem_address, access_size, sign_extend, byte_reverse);
         q.push_back(e);
         next_free = e.due;
      end
      acc_cyc.push_back(cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      logic eov, erdy;
      eov = q.size() > 0 && cyc >= q[0].due;
      if (rst) begin
         chk("ready_in_reset", input_ready, 0);
         if (rst_prev) chk("valid_in_reset", output_valid, 0);
         q.delete();
         pend_n = 0;
         next_free = 0;
      end else begin
         for (int i = 0; i < pend_n; i++) bm[pend_a[i]] = pend_v[i];
         pend_n = 0;
         erdy = cyc >= next_free && (!eov || output_ready);
         chk("input_ready", input_ready, erdy);
         chk("output_valid", output_valid, eov);
         if (eov) begin
            chk("rs_id_out", rs_id_out, q[0].rs);
            chk("result_reg_addr_out", result_reg_addr_out, q[0].rd);
            chk("mem_read_data", mem_read_data, q[0].d);
            if (output_ready) begin
               last_d = mem_read_data;
               void'(q.pop_front());
            end
         end
         if (input_valid && input_ready) accept();
      end
      rst_prev = rst;
   end

   initial forever begin
      @(posedge clk);
      #2;
      output_ready = or_mode == 2 ? 1'($urandom_range(0, 1)) : or_mode == 1;
   end

   task automatic req(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic sx,
                      input logic rv, input logic [31:0] d, input logic [RW-1:0] rs, input logic [4:0] rd);
      int t;
      logic ok;
      t = 0;
      input_valid = 1; is_write = w; mem_address = a; access_size = sz; sign_extend = sx;
      byte_reverse = rv; mem_write_data = d; rs_id_in = rs; result_reg_addr_in = rd;
      do begin
         @(negedge clk);
         ok = input_ready;
         @(posedge clk);
         #1;
         t++;
      end while (!ok && t < 200);
      chk("req_accepted", ok, 1);
      input_valid = 0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q.size() > 0 || cyc < next_free) && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic ld(input string nm, input logic [31:0] a, input logic [1:0] sz, input logic sx,
                     input logic rv, input logic [31:0] want);
      last_d = 'x;
      req(0, a, sz, sx, rv, 0, 7'($urandom), 5'($urandom));
      drain();
      chk(nm, last_d, want);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", output_valid, 0);
      chk("rst_rs_id", rs_id_out, 0);
      chk("rst_rd", result_reg_addr_out, 0);
      chk("rst_data", mem_read_data, 0);
      @(posedge clk);
      #1;
      rst = 0;

      for (int w = 0; w < D; w++) req(1, ($urandom & ~32'(NB - 1)) | 32'(w * 4), 2, 0, 0, $urandom, 0, 0);

      req(1, 32'h100, 2, 0, 0, 32'h11223344, 0, 0);
      req(0, 32'h100, 2, 0, 0, 0, 7'd5, 5'd3);
      drain();
      chk("aligned_load", last_d, 32'h11223344);

      req(1, 32'h103, 2, 0, 0, 32'hAABBCCDD, 0, 0);
      @(negedge clk);
      chk("ready_low_second", input_ready, 0);
      @(posedge clk);
      #1;
      chk("model_split_w0", mload(32'h100, 2, 0, 0), 32'h112233AA);
      ld("split_w0", 32'h100, 2, 0, 0, 32'h112233AA);
      ld("split_load", 32'h103, 2, 0, 0, 32'hAABBCCDD);
      ld("split_w1", 32'h104, 2, 0, 0, {24'hBBCCDD, bm[32'h107]});

      req(1, 32'h200, 0, 0, 0, 32'h80, 0, 0);
      chk("model_sext", mload(32'h200, 0, 1, 0), 32'hFFFFFF80);
      ld("byte_sext", 32'h200, 0, 1, 0, 32'hFFFFFF80);
      ld("byte_zext", 32'h200, 0, 0, 0, 32'h00000080);
      req(1, 32'h204, 2, 0, 0, 32'h01020304, 0, 0);
      ld("word_rev", 32'h204, 2, 0, 1, 32'h04030201);
      ld("half_rev_sext", 32'h205, 1, 1, 1, 32'h00000302);
      req(1, 32'h208, 1, 0, 1, 32'h0000A1B2, 0, 0);
      ld("half_store_rev", 32'h208, 1, 1, 0, 32'hFFFFB2A1);

      req(1, 32'(NB - 2), 2, 0, 0, 32'hCAFEBABE, 0, 0);
      ld("wrap_word", 32'(NB - 2), 2, 0, 0, 32'hCAFEBABE);
      ld("wrap_head", 32'h0, 1, 0, 0, 32'h0000BABE);
      ld("wrap_tail", 32'(NB - 2), 1, 0, 0, 32'h0000CAFE);

      or_mode = 0;
      req(0, 32'h100, 2, 0, 0, 0, 7'd9, 5'd1);
      @(posedge clk);
      #1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", output_valid, 1);
         chk("bp_ready", input_ready, 0);
         chk("bp_data", mem_read_data, 32'h112233AA);
         @(posedge clk);
         #1;
      end
      or_mode = 1;
      @(negedge clk);
      chk("bp_release_ready", input_ready, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_released", output_valid, 0);
      @(posedge clk);
      #1;

      acc_cyc.delete();
      for (int i = 0; i < 4; i++) req(0, 32'h100 + 32'(4 * i), 2, 0, 0, 0, 7'(20 + i), 5'(i));
      drain();
      chk("b2b_count", acc_cyc.size(), 4);
      for (int i = 0; i + 1 < acc_cyc.size(); i++) chk("b2b_gap", acc_cyc[i + 1] - acc_cyc[i], 2);

      req(1, 32'h300, 2, 0, 0, 32'h12345678, 0, 0);
      req(1, 32'h304, 2, 0, 0, 32'h99999999, 0, 0);
      req(1, 32'h302, 2, 0, 0, 32'h55667788, 0, 0);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      @(negedge clk);
      chk("idle_after_reset", input_ready, 1);
      chk("valid_after_reset", output_valid, 0);
      @(posedge clk);
      #1;
      ld("rst_part0", 32'h300, 2, 0, 0, 32'h12345566);
      ld("rst_part1_dropped", 32'h304, 2, 0, 0, 32'h99999999);

      req(0, 32'h301, 2, 0, 0, 0, 7'd1, 5'd1);
      rst = 1;
      @(posedge clk);
      #1;
      rst = 0;
      repeat (4) @(posedge clk);
      #1;
      @(negedge clk);
      chk("load_discarded", output_valid, 0);
      @(posedge clk);
      #1;

      for (int k = 0; k < 400; k++) begin
         logic [31:0] a;
         int low;
         or_mode = $urandom_range(1, 2);
         low = $urandom_range(0, 3) == 0 ? $urandom_range(NB - 8, NB - 1) : $urandom_range(0, 47);
         a = ($urandom & ~32'(NB - 1)) | 32'(low);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         req(1'($urandom), a, 2'($urandom), 1'($urandom), 1'($urandom), $urandom, 7'($urandom), 5'($urandom));
      end
      or_mode = 1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
      $fatal(1);
   end
endmodule

// File: doc/lsu_data_mem.md
Name: lsu_data_mem

Overview:
- Parametrised second-generation data memory for the load/store unit. It accepts one tagged load or store per handshake.
- Each access is sized (byte, halfword, word) and may be misaligned. An access that crosses a word boundary is split into two internal word accesses.
- Loads can be zero- or sign-extended and byte-reversed (lwbrx/sthbrx-style). Stores can be byte-reversed.
- The block has full ready/valid backpressure on the result side. Results go back to the reservation-station/CDB side tagged with rs_id and the destination register.

Parameters:
RS_ID_WIDTH, 7, width of reservation-station tag
MEMORY_DEPTH, 32768, number of 32-bit words; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
input_valid  in  1  request valid
input_ready  out  1  request accepted when both valid and ready are high
rs_id_in  in  RS_ID_WIDTH  tag of the request
result_reg_addr_in  in  5  destination GPR of a load
mem_address  in  32  byte address; bit 0 is MSB, bits [30:31] are the byte offset
is_write  in  1  1 = store, 0 = load
access_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
sign_extend  in  1  loads only; sign-extend byte/half
byte_reverse  in  1  reverse byte order of half/word data (load and store)
mem_write_data  in  32  store data, right-aligned (byte in [24:31], half in [16:31])
output_valid  out  1  load result valid
output_ready  in  1  consumer accepts result
rs_id_out  out  RS_ID_WIDTH  tag of result
result_reg_addr_out  out  5  destination GPR of result
mem_read_data  out  32  load result, right-aligned, extended

Behaviour:
- Memory layout: big-endian. Byte k of a word is bits [8k:8k+7].
- Word index = mem_address[0:29] mod MEMORY_DEPTH. Second word = (index+1) mod MEMORY_DEPTH, which wraps from the last word to word 0.
- Internal RAM: synchronous write, registered read with one cycle of latency. RAM contents are not reset.
- Split condition: offset + size_bytes > 4. Examples: half at offset 3; word at offset 1, 2 or 3.
- Store split: part 0 writes only the bytes that fall in the first word; part 1 writes the remaining bytes at the second word. Bytes outside the access mask are never modified.
- Byte reversal is applied to store data before lane placement. For loads it is applied after the bytes are gathered, and before extension.
- Loads: result = gathered bytes, right-aligned.
  - Zero extension when sign_extend = 0.
  - Otherwise the MSB of the access is replicated. Sign extension of a word is a no-op.
- State machine:
  - IDLE: accept a request when input_valid & input_ready. An aligned store completes in that cycle and the FSM stays in IDLE. A split access goes to SECOND. An unsplit load goes to RESP.
  - SECOND: issue the second word access; input_ready = 0. A store then goes to IDLE; a load goes to RESP.
  - RESP: RAM data is available. The result is registered into the output stage at the end of this cycle, then the FSM goes to IDLE.
- input_ready = (state == IDLE) & (!output_valid | output_ready). At most one load is in flight.
- Latency, request accepted at edge of cycle T:
  - Aligned load: output_valid high in T+2.
  - Split load: output_valid high in T+3.
  - Aligned store: memory updated at the T edge; next request can be accepted in T+1.
  - Split store: second word written at the T+1 edge; next request can be accepted in T+2.
- Output stage:
  - output_valid stays high, and rs_id_out, result_reg_addr_out and mem_read_data stay stable, until output_valid & output_ready.
  - The output clears when output_valid & output_ready, unless a new result loads in the same cycle; in that case the new result replaces it with no bubble.
- Stores never assert output_valid.
- Reset: state = IDLE, output_valid = 0, rs_id_out = 0, result_reg_addr_out = 0, mem_read_data = 0, input_ready = 0 during reset.
- Reset mid-split: a pending part 1 store is dropped (part 0 may already be written), and a pending load is discarded.
- Reset has priority over every other event in the same cycle.

Test Plan:
- Aligned word store then load: store 0x11223344 @0x100; load word @0x100, rs_id = 5, rd = 3 -> mem_read_data = 0x11223344, rs_id_out = 5, result_reg_addr_out = 3, output_valid at T+2.
- Split word store then load: store 0xAABBCCDD @0x103 -> word 0x100 byte 3 = AA, word 0x104 bytes 0-2 = BBCCDD, other bytes unchanged. Load word @0x103 -> 0xAABBCCDD at T+3; input_ready low during SECOND.
- Extension and reverse: byte 0x80 @0x200. Load byte with sign_extend = 1 -> 0xFFFFFF80; with sign_extend = 0 -> 0x00000080. Word 0x01020304 with byte_reverse = 1 -> 0x04030201.
- Wrap-around: word store 0xCAFEBABE @ byte (MEMORY_DEPTH*4 - 2) -> CAFE lands in bytes 2-3 of the last word, BABE in bytes 0-1 of word 0. Read back matches.
- Backpressure: hold output_ready = 0 for 5 cycles after a load -> output_valid stays 1 with stable data and input_ready = 0. Release -> handshake in 1 cycle. Back-to-back loads with output_ready = 1 -> one result every 2 cycles.
- Reset mid-split: split store accepted, rst asserted in the SECOND cycle -> part 1 bytes not written, output_valid = 0, FSM in IDLE after reset.
